// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic unit (multiplier and divider).
package arith_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10,
    StZero = 2'b11
  } arith_state_e;

endpackage

// File: rtl/shift_sub_datapath.sv
// Restoring-division datapath: Q/R/D registers, one shift-subtract step per enabled edge,
// and the iteration counter.
module shift_sub_datapath #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] q_next,
  output logic [N-1:0] r_next,
  output logic         last_iter
);

  localparam int unsigned CW = $clog2(N);

  logic [N-1:0]  q_q, r_q, d_q;
  logic [CW-1:0] count_q;
  logic [N:0]    rs, t;
  logic [N-1:0]  qs;

  // The partial remainder is always below D after a step, so N bits hold it.
  always_comb begin
    rs     = {r_q, q_q[N-1]};
    qs     = {q_q[N-2:0], 1'b0};
    t      = rs - {1'b0, d_q};
    q_next = t[N] ? qs : {q_q[N-2:0], 1'b1};
    r_next = t[N] ? rs[N-1:0] : t[N-1:0];
  end

  assign last_iter = (count_q == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      count_q <= '0;
    end else if (load) begin
      q_q     <= dividend;
      r_q     <= '0;
      d_q     <= divisor;
      count_q <= '0;
    end else if (step) begin
      q_q     <= q_next;
      r_q     <= r_next;
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/shift_sub_div.sv
// Sequential restoring unsigned divider: go/done handshake, one quotient bit per clock.
module shift_sub_div
  import arith_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         done,
  output logic         busy,
  output logic         div_by_zero
);

  arith_state_e state_q, state_d;
  logic [N-1:0] quotient_q, quotient_d;
  logic [N-1:0] remainder_q, remainder_d;
  logic         dbz_q, dbz_d;
  logic         load, step, last_iter;
  logic [N-1:0] q_next, r_next;

  shift_sub_datapath #(
    .N (N)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .dividend  (dividend),
    .divisor   (divisor),
    .q_next    (q_next),
    .r_next    (r_next),
    .last_iter (last_iter)
  );

  always_comb begin
    state_d     = state_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    load        = 1'b0;
    step        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = StZero;
          end else begin
            load    = 1'b1;
            dbz_d   = 1'b0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        step = 1'b1;
        if (last_iter) begin
          quotient_d  = q_next;
          remainder_d = r_next;
          state_d     = StDone;
        end
      end
      StDone, StZero: begin
        // No auto-restart: the requester must drop go before the next operation.
        if (!go) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign done        = (state_q == StDone) || (state_q == StZero);
  assign busy        = (state_q == StCalc);

endmodule

// File: tb/tb_shift_sub_div.sv
// Directed self-checking bench for shift_sub_div with N=4.
module tb_shift_sub_div;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         go = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient, remainder;
  logic         done, busy, div_by_zero;

  int total = 0;
  int bad = 0;

  shift_sub_div #(
    .N (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Pulse go for one edge, then wait (bounded) for done; cyc counts edges from the start edge.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, output int cyc);
    @(negedge clk);
    go = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    go = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL op_timeout %0d/%0d: done=%b after %0d cycles, required done=1", a, b, done, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++;
    if ({quotient, remainder, done, busy, div_by_zero} !== '0) begin
      bad++;
      $display("FAIL reset_state: q=%0d r=%0d done=%b busy=%b dbz=%b, required all 0",
               quotient, remainder, done, busy, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    go = 1'b1; dividend = 4'd13; divisor = 4'd4;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      go = 1'b0;
      total++;
      if (busy !== (c <= 4) || done !== (c == 5)) begin
        bad++;
        $display("FAIL basic_timing cycle %0d: busy=%b done=%b, required busy=%b done=%b",
                 c, busy, done, c <= 4, c == 5);
      end
    end
    total++;
    if (quotient !== 4'd3 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL basic_13_4: q=%0d r=%0d dbz=%b, required q=3 r=1 dbz=0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_vectors();
    logic [N-1:0] va [3] = '{4'd15, 4'd3, 4'd9};
    logic [N-1:0] vb [3] = '{4'd1, 4'd9, 4'd3};
    logic [N-1:0] vq [3] = '{4'd15, 4'd0, 4'd3};
    logic [N-1:0] vr [3] = '{4'd0, 4'd3, 4'd0};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], cyc);
      total++;
      if (quotient !== vq[i] || remainder !== vr[i] || cyc != N + 1) begin
        bad++;
        $display("FAIL vec_%0d_%0d: q=%0d r=%0d lat=%0d, required q=%0d r=%0d lat=%0d",
                 va[i], vb[i], quotient, remainder, cyc, vq[i], vr[i], N + 1);
      end
    end
  endtask

  task automatic test_zero_divisor();
    int cyc;
    run_op(4'd7, 4'd0, cyc);
    total++;
    if (quotient !== 4'd15 || remainder !== 4'd7 || div_by_zero !== 1'b1 || cyc != 1) begin
      bad++;
      $display("FAIL zero_div: q=%0d r=%0d dbz=%b lat=%0d, required q=15 r=7 dbz=1 lat=1",
               quotient, remainder, div_by_zero, cyc);
    end
    @(negedge clk);
    go = 1'b1; dividend = 4'd6; divisor = 4'd2;
    @(negedge clk);
    go = 1'b0;
    total++;
    if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL dbz_clear_at_start: dbz=%b busy=%b, required dbz=0 busy=1",
               div_by_zero, busy);
    end
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (quotient !== 4'd3 || remainder !== 4'd0 || div_by_zero !== 1'b0 || !done) begin
      bad++;
      $display("FAIL after_zero_6_2: q=%0d r=%0d dbz=%b done=%b, required q=3 r=0 dbz=0 done=1",
               quotient, remainder, div_by_zero, done);
    end
  endtask

  task automatic test_ignore_inputs();
    @(negedge clk);
    go = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(negedge clk);
    go = 1'b0; dividend = 4'd1; divisor = 4'd1;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int c = 0; c < 20 && !done; c++) @(negedge clk);
    total++;
    if (quotient !== 4'd2 || remainder !== 4'd2 || !done) begin
      bad++;
      $display("FAIL ignore_inputs_12_5: q=%0d r=%0d done=%b, required q=2 r=2 done=1",
               quotient, remainder, done);
    end
  endtask

  task automatic test_hold_go();
    @(negedge clk);
    go = 1'b1; dividend = 4'd14; divisor = 4'd3;
    for (int c = 0; c < 20 && !done; c++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || quotient !== 4'd4 || remainder !== 4'd2) begin
        bad++;
        $display("FAIL hold_go cycle %0d: done=%b busy=%b q=%0d r=%0d, required 1 0 4 2",
                 c, done, busy, quotient, remainder);
      end
    end
    go = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 4'd4) begin
      bad++;
      $display("FAIL release_go: done=%b busy=%b q=%0d, required done=0 busy=0 q=4",
               done, busy, quotient);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    @(negedge clk);
    go = 1'b1; dividend = 4'd13; divisor = 4'd4;
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({quotient, remainder, done, busy, div_by_zero} !== '0) begin
      bad++;
      $display("FAIL async_reset: q=%0d r=%0d done=%b busy=%b dbz=%b, required all 0",
               quotient, remainder, done, busy, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(4'd9, 4'd3, cyc);
    total++;
    if (quotient !== 4'd3 || remainder !== 4'd0 || cyc != N + 1) begin
      bad++;
      $display("FAIL post_reset_9_3: q=%0d r=%0d lat=%0d, required q=3 r=0 lat=%0d",
               quotient, remainder, cyc, N + 1);
    end
  endtask

  task automatic test_exhaustive();
    int cyc;
    logic [N-1:0] eq, er;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(N'(a), N'(b), cyc);
        if (b == 0) begin
          eq = '1;
          er = N'(a);
        end else begin
          eq = N'(a / b);
          er = N'(a % b);
        end
        total++;
        if (quotient !== eq || remainder !== er || div_by_zero !== (b == 0)) begin
          bad++;
          $display("FAIL exhaustive %0d/%0d: q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                   a, b, quotient, remainder, div_by_zero, eq, er, b == 0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_zero_divisor();
    test_ignore_inputs();
    test_hold_go();
    test_async_reset();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
